// File: rtl/commit_decider.sv
// Vote-collection FSM deciding one transaction's outcome (accept/commit/reject).
// Optional ACEITO confirmation timeout is enabled by defining DECIDER_ACK_TIMEOUT_EN.
module commit_decider #(
  parameter int N_PART  = 4,
  parameter int TIMEOUT = 50,
  parameter int HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_PART-1:0] voto_valido,
  input  logic [N_PART-1:0] voto,
  input  logic              confirma,
  output logic              aceito,
  output logic              comprometido,
  output logic              rejeitado,
  output logic              ocupado
);

  localparam int MAX_LIMIT = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int CW        = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLETA,
    ACEITO,
    COMPROMETIDO,
    REJEITADO
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_PART-1:0] recebido_q, recebido_d;
  logic [N_PART-1:0] favor_q, favor_d;
  logic              aceito_q, comprometido_q, rejeitado_q, ocupado_q;

  // Decisions look at latched votes merged with this cycle's first-time strobes.
  logic [N_PART-1:0] accepted;
  logic [N_PART-1:0] recebidoMerged;
  logic [N_PART-1:0] favorMerged;
  logic              anyNo;
  logic              allYes;

  assign accepted       = voto_valido & ~recebido_q;
  assign recebidoMerged = recebido_q | accepted;
  assign favorMerged    = favor_q | (accepted & voto);
  assign anyNo          = |(recebidoMerged & ~favorMerged);
  assign allYes         = (&recebidoMerged) & (&favorMerged);

  always_comb begin
    state_d    = state_q;
    recebido_d = recebido_q;
    favor_d    = favor_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLETA;
          recebido_d = '0;
          favor_d    = '0;
        end
      end
      COLETA: begin
        recebido_d = recebidoMerged;
        favor_d    = favorMerged;
        if (anyNo) begin
          state_d = REJEITADO;
        end else if (allYes) begin
          state_d = ACEITO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = REJEITADO;
        end
      end
      ACEITO: begin
        if (confirma) begin
          state_d = COMPROMETIDO;
`ifdef DECIDER_ACK_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = REJEITADO;
`endif
        end
      end
      COMPROMETIDO, REJEITADO: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE has no limit, so its counter is parked at zero to keep it from wrapping.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
`ifndef DECIDER_ACK_TIMEOUT_EN
    end else if (state_q == ACEITO) begin
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      recebido_q     <= '0;
      favor_q        <= '0;
      aceito_q       <= 1'b0;
      comprometido_q <= 1'b0;
      rejeitado_q    <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      recebido_q     <= recebido_d;
      favor_q        <= favor_d;
      aceito_q       <= (state_d == ACEITO);
      comprometido_q <= (state_d == COMPROMETIDO);
      rejeitado_q    <= (state_d == REJEITADO);
      ocupado_q      <= (state_d != IDLE);
    end
  end

  assign aceito       = aceito_q;
  assign comprometido = comprometido_q;
  assign rejeitado    = rejeitado_q;
  assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_commit_decider.sv
// Directed self-checking bench for commit_decider (N_PART=4, TIMEOUT=50, HOLD=8).
// Macro-dependent ACEITO behaviour is checked according to DECIDER_ACK_TIMEOUT_EN.
module tb_commit_decider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] voto_valido;
  logic [3:0] voto;
  logic       confirma;
  logic       aceito;
  logic       comprometido;
  logic       rejeitado;
  logic       ocupado;

  int testsRun;
  int testsFailed;

  commit_decider #(
    .N_PART (4),
    .TIMEOUT(50),
    .HOLD   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .voto_valido (voto_valido),
    .voto        (voto),
    .confirma    (confirma),
    .aceito      (aceito),
    .comprometido(comprometido),
    .rejeitado   (rejeitado),
    .ocupado     (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_txn();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ocupado === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    testsRun++;
    if (ocupado !== 1'b0) begin
      $display("[TB] FAIL %s: ocupado=%b after %0d cycles, required 0", name, ocupado, n);
      testsFailed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    voto_valido = 4'b0000;
    voto = 4'b0000;
    confirma = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({aceito, comprometido, rejeitado, ocupado} !== 4'b0000) begin
      $display("[TB] FAIL reset_outputs: got %b, required 0000",
               {aceito, comprometido, rejeitado, ocupado});
      testsFailed++;
    end
    rst = 1'b0;
    tick();
    testsRun++;
    if (ocupado !== 1'b0) begin
      $display("[TB] FAIL idle_after_reset: ocupado=%b, required 0", ocupado);
      testsFailed++;
    end
  endtask

  task automatic test_all_yes();
    int high;
    begin_txn();
    testsRun++;
    if ({aceito, comprometido, rejeitado, ocupado} !== 4'b0001) begin
      $display("[TB] FAIL start_busy: got %b, required 0001",
               {aceito, comprometido, rejeitado, ocupado});
      testsFailed++;
    end
    for (int i = 0; i < 4; i++) begin
      voto_valido = 4'b0001 << i;
      voto = 4'b1111;
      tick();
      testsRun++;
      if (aceito !== (i == 3)) begin
        $display("[TB] FAIL all_yes_vote%0d: aceito=%b, required %b", i, aceito, (i == 3));
        testsFailed++;
      end
    end
    voto_valido = 4'b0000;
    repeat (2) tick();
    testsRun++;
    if (aceito !== 1'b1) begin
      $display("[TB] FAIL aceito_hold: aceito=%b, required 1", aceito);
      testsFailed++;
    end
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    testsRun++;
    if ({aceito, comprometido, rejeitado} !== 3'b010) begin
      $display("[TB] FAIL commit: got %b, required 010", {aceito, comprometido, rejeitado});
      testsFailed++;
    end
    high = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (comprometido !== 1'b1) break;
      high++;
    end
    testsRun++;
    if (high !== 8) begin
      $display("[TB] FAIL commit_hold_len: %0d cycles, required 8", high);
      testsFailed++;
    end
    testsRun++;
    if ({aceito, comprometido, rejeitado, ocupado} !== 4'b0000) begin
      $display("[TB] FAIL commit_to_idle: got %b, required 0000",
               {aceito, comprometido, rejeitado, ocupado});
      testsFailed++;
    end
  endtask

  task automatic test_early_reject();
    int high;
    begin_txn();
    voto_valido = 4'b0100;
    voto = 4'b0000;
    tick();
    testsRun++;
    if ({aceito, rejeitado} !== 2'b01) begin
      $display("[TB] FAIL early_reject: aceito,rejeitado=%b, required 01", {aceito, rejeitado});
      testsFailed++;
    end
    voto_valido = 4'b1011;
    voto = 4'b1111;
    high = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (rejeitado !== 1'b1) break;
      high++;
    end
    voto_valido = 4'b0000;
    testsRun++;
    if (high !== 8) begin
      $display("[TB] FAIL reject_hold_len: %0d cycles, required 8", high);
      testsFailed++;
    end
    testsRun++;
    if ({aceito, comprometido, ocupado} !== 3'b000) begin
      $display("[TB] FAIL reject_to_idle: got %b, required 000", {aceito, comprometido, ocupado});
      testsFailed++;
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    testsRun++;
    if (ocupado !== 1'b1) begin
      $display("[TB] FAIL first_idle_start: ocupado=%b, required 1", ocupado);
      testsFailed++;
    end
    voto_valido = 4'b0001;
    voto = 4'b0000;
    tick();
    voto_valido = 4'b0000;
    wait_idle("b2b_idle");
  endtask

  task automatic test_repeat_strobe();
    begin_txn();
    voto_valido = 4'b0001;
    voto = 4'b0001;
    tick();
    voto = 4'b0000;
    tick();
    testsRun++;
    if ({aceito, rejeitado} !== 2'b00) begin
      $display("[TB] FAIL repeat_ignored: aceito,rejeitado=%b, required 00", {aceito, rejeitado});
      testsFailed++;
    end
    voto_valido = 4'b1110;
    voto = 4'b1110;
    tick();
    voto_valido = 4'b0000;
    testsRun++;
    if ({aceito, rejeitado} !== 2'b10) begin
      $display("[TB] FAIL repeat_complete: aceito,rejeitado=%b, required 10", {aceito, rejeitado});
      testsFailed++;
    end
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    wait_idle("repeat_idle");
  endtask

  task automatic test_timeout();
    begin_txn();
    voto_valido = 4'b0111;
    voto = 4'b1111;
    tick();
    voto_valido = 4'b0000;
    repeat (48) tick();
    testsRun++;
    if ({rejeitado, ocupado} !== 2'b01) begin
      $display("[TB] FAIL timeout_early: rejeitado,ocupado=%b at cycle 49, required 01",
               {rejeitado, ocupado});
      testsFailed++;
    end
    tick();
    testsRun++;
    if (rejeitado !== 1'b1) begin
      $display("[TB] FAIL timeout_edge: rejeitado=%b at cycle 50, required 1", rejeitado);
      testsFailed++;
    end
    wait_idle("timeout_idle");

    begin_txn();
    voto_valido = 4'b0111;
    tick();
    voto_valido = 4'b0000;
    repeat (48) tick();
    voto_valido = 4'b1000;
    voto = 4'b1111;
    tick();
    voto_valido = 4'b0000;
    testsRun++;
    if ({aceito, rejeitado} !== 2'b10) begin
      $display("[TB] FAIL timeout_late_vote: aceito,rejeitado=%b, required 10", {aceito, rejeitado});
      testsFailed++;
    end
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    wait_idle("late_vote_idle");
  endtask

  task automatic test_reset_mid();
    begin_txn();
    voto_valido = 4'b1111;
    voto = 4'b1111;
    tick();
    voto_valido = 4'b0000;
    #3;
    rst = 1'b1;
    #1;
    testsRun++;
    if ({aceito, comprometido, rejeitado, ocupado} !== 4'b0000) begin
      $display("[TB] FAIL async_reset: got %b, required 0000",
               {aceito, comprometido, rejeitado, ocupado});
      testsFailed++;
    end
    #1;
    rst = 1'b0;
    begin_txn();
    voto_valido = 4'b0111;
    tick();
    voto_valido = 4'b0000;
    testsRun++;
    if ({aceito, rejeitado, ocupado} !== 3'b001) begin
      $display("[TB] FAIL post_reset_partial: got %b, required 001", {aceito, rejeitado, ocupado});
      testsFailed++;
    end
    voto_valido = 4'b1000;
    tick();
    voto_valido = 4'b0000;
    testsRun++;
    if (aceito !== 1'b1) begin
      $display("[TB] FAIL post_reset_accept: aceito=%b, required 1", aceito);
      testsFailed++;
    end
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    wait_idle("post_reset_idle");
  endtask

  task automatic test_ack_timeout();
    begin_txn();
    voto_valido = 4'b1111;
    voto = 4'b1111;
    tick();
    voto_valido = 4'b0000;
`ifdef DECIDER_ACK_TIMEOUT_EN
    repeat (49) tick();
    testsRun++;
    if (aceito !== 1'b1) begin
      $display("[TB] FAIL ack_wait: aceito=%b at cycle 49, required 1", aceito);
      testsFailed++;
    end
    tick();
    testsRun++;
    if ({aceito, rejeitado} !== 2'b01) begin
      $display("[TB] FAIL ack_timeout: aceito,rejeitado=%b, required 01", {aceito, rejeitado});
      testsFailed++;
    end
    wait_idle("ack_timeout_idle");
    begin_txn();
    voto_valido = 4'b1111;
    tick();
    voto_valido = 4'b0000;
    repeat (49) tick();
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    testsRun++;
    if ({comprometido, rejeitado} !== 2'b10) begin
      $display("[TB] FAIL ack_last_confirm: comprometido,rejeitado=%b, required 10",
               {comprometido, rejeitado});
      testsFailed++;
    end
`else
    repeat (60) tick();
    testsRun++;
    if ({aceito, rejeitado} !== 2'b10) begin
      $display("[TB] FAIL ack_no_timeout: aceito,rejeitado=%b, required 10", {aceito, rejeitado});
      testsFailed++;
    end
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    testsRun++;
    if (comprometido !== 1'b1) begin
      $display("[TB] FAIL ack_late_confirm: comprometido=%b, required 1", comprometido);
      testsFailed++;
    end
`endif
    wait_idle("ack_idle");
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_all_yes();
    test_early_reject();
    test_back_to_back();
    test_repeat_strobe();
    test_timeout();
    test_reset_mid();
    test_ack_timeout();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/commit_decider.md
# commit_decider

Vote-collection FSM that decides the outcome of one transaction and drives the level status lines `aceito`, `comprometido` and `rejeitado`. The state-change edge detector consumes these lines directly and turns each rising edge into its one-cycle pulse. Each transaction runs in order: start, collect one vote per participant, wait for commit confirmation, hold the outcome, then return to idle.

## Interface
Parameters:
- `N_PART`, default 4: number of voting participants.
- `TIMEOUT`, default 50: cycles allowed in COLETA, and in ACEITO when the macro is defined. Must be ≥ 2.
- `HOLD`, default 8: cycles the final outcome is held before returning to IDLE. Must be ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `start`  in  1: begin a transaction. Sampled only in IDLE.
- `voto_valido`  in  N_PART: per-participant vote strobe.
- `voto`  in  N_PART: per-participant vote value. 1 = yes, 0 = no.
- `confirma`  in  1: commit confirmation. Sampled only in ACEITO.
- `aceito`  out  1: high while in ACEITO.
- `comprometido`  out  1: high while in COMPROMETIDO.
- `rejeitado`  out  1: high while in REJEITADO.
- `ocupado`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, COLETA, ACEITO, COMPROMETIDO, REJEITADO.
- All outputs are registered and decoded from the state register.
- `aceito`, `comprometido` and `rejeitado` are mutually exclusive. All three are 0 in IDLE and COLETA.
- Per-participant registers: `recebido[N_PART]`, `favor[N_PART]`. Both are cleared on entry to COLETA.
- Counter `cnt`: width `$clog2(max(TIMEOUT,HOLD)+1)`. Cleared on every state change. Increments by 1 each cycle while the state is held. Never wraps, because every state exits at or before its limit.
- **IDLE:**
  - `start` = 1 → COLETA.
  - All other inputs are ignored.
- **COLETA:**
  - Vote latching: when `voto_valido[i]` = 1 and `recebido[i]` = 0, set `recebido[i]` and latch `favor[i]` = `voto[i]`.
  - Repeat strobes from a participant that has already voted are ignored; its first vote stands.
  - Decisions are evaluated on the latched flags merged with the current cycle's accepted strobes, in this priority:
    1. Any accepted vote is 0 → REJEITADO.
    2. Otherwise, all N_PART votes received and all yes → ACEITO.
    3. Otherwise, `cnt` = TIMEOUT-1 → REJEITADO (timeout).
  - Simultaneous events: a completing vote on the timeout cycle wins. All yes → ACEITO; any no → REJEITADO.
  - `start` is ignored.
- **ACEITO:**
  - `confirma` = 1 → COMPROMETIDO.
  - Timeout behaviour depends on the macro; see Configuration.
- **COMPROMETIDO / REJEITADO:**
  - Hold until `cnt` = HOLD-1, then → IDLE.
  - All inputs are ignored.
- **Reset (`rst` = 1, at any time including mid-transaction):**
  - State → IDLE.
  - `cnt`, `recebido` and `favor` are cleared.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - Any transaction in progress is discarded. No outcome is produced for it.

## Timing
- `start` sampled at edge E0 → `ocupado` = 1 after E0.
- Completing yes vote presented before edge Ek → `aceito` = 1 after Ek. Latency: 1 cycle.
- Any no vote presented before edge Ek → `rejeitado` = 1 after Ek.
- No decision → `rejeitado` = 1 exactly TIMEOUT cycles after entry to COLETA.
- `confirma` sampled at edge Ec → `aceito` = 0 and `comprometido` = 1 after Ec. Latency: 1 cycle.
- COMPROMETIDO and REJEITADO each last exactly HOLD cycles, then IDLE and `ocupado` = 0.
- A new `start` is accepted on the first IDLE cycle. Back-to-back transactions are therefore separated by exactly one IDLE cycle.
- Each outcome output has exactly one rising edge per transaction. No output glitches, since all outputs are registered.

## Configuration
- Macro: `DECIDER_ACK_TIMEOUT_EN`.
- **Defined:**
  - ACEITO with `cnt` = TIMEOUT-1 and `confirma` = 0 → REJEITADO.
  - `confirma` on that same cycle wins → COMPROMETIDO.
- **Undefined:**
  - ACEITO waits indefinitely for `confirma`.
  - `cnt` is held at 0 in ACEITO.

## Test plan
- **All yes:** N_PART = 4. `start`, then votes 1,1,1,1 on separate cycles, then `confirma` 3 cycles later → `aceito` high 3 cycles → `comprometido` high 8 cycles → IDLE, `ocupado` = 0.
- **Early rejection:** participant 2 votes 0 as the first vote → `rejeitado` = 1 the next cycle, held 8 cycles. Later strobes from other participants are ignored.
- **Repeat strobe:** participant 0 votes 1, then 0 → second strobe ignored. All-yes completion from the others → `aceito` = 1.
- **Timeout boundary:** only 3 votes arrive → `rejeitado` rises exactly 50 cycles after COLETA entry. In a second run, the 4th yes vote on cycle 49 → `aceito` = 1, no rejection.
- **Reset mid-operation:** `rst` pulsed while in ACEITO → outputs 0 immediately, state IDLE. The following `start` runs a clean transaction with `recebido` all 0.
- **Macro on:** ACEITO with no `confirma` for 50 cycles → `rejeitado` = 1. `confirma` on cycle 49 → `comprometido` = 1.
